// File: rtl/multiword_add_sequencer.sv
// Sequences a wide add through an external 3-bit adder slice, one chunk per clock, LSB first.
// Optional signed-overflow output is enabled by defining MULTIWORD_ADD_OVF_EN.
module multiword_add_sequencer #(
  parameter int N_CHUNKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3*N_CHUNKS-1:0] op_a,
  input  logic [3*N_CHUNKS-1:0] op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [3*N_CHUNKS-1:0] result,
  output logic                  cout,
`ifdef MULTIWORD_ADD_OVF_EN
  output logic                  ovf,
`endif
  output logic [2:0]            add_a,
  output logic [2:0]            add_b,
  output logic                  add_cin,
  input  logic [2:0]            add_sum,
  input  logic                  add_cout
);

  localparam int W  = 3 * N_CHUNKS;
  localparam int IW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic          carry_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  result_reg;
  logic          cout_reg;
  logic          last_chunk;

  assign last_chunk = (idx_reg == IW'(N_CHUNKS - 1));

`ifdef MULTIWORD_ADD_OVF_EN
  logic ovf_reg;
  logic ovf_next;

  // The last chunk holds the MSB, so add_sum[2] is the final result[W-1].
  assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (add_sum[2] != a_reg[W-1]);
  assign ovf      = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg      <= op_a;
            b_reg      <= op_b;
            carry_reg  <= cin;
            idx_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_reg    <= 1'b0;
`endif
            state_reg  <= RUN;
          end
        end
        RUN: begin
          result_reg[3*idx_reg +: 3] <= add_sum;
          carry_reg                  <= add_cout;
          if (last_chunk) begin
            cout_reg  <= add_cout;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf_reg   <= ovf_next;
`endif
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Slice inputs are quiet outside RUN so the shared adder sees no stale operands.
  always_comb begin
    add_a   = 3'b000;
    add_b   = 3'b000;
    add_cin = 1'b0;
    if (state_reg == RUN) begin
      add_a   = a_reg[3*idx_reg +: 3];
      add_b   = b_reg[3*idx_reg +: 3];
      add_cin = carry_reg;
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (N_CHUNKS=4) with a behavioural 3-bit adder slice.
// Checks the ovf output too when MULTIWORD_ADD_OVF_EN is defined.
module tb_multiword_add_sequencer;
  localparam int N = 4;
  localparam int W = 3 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic [2:0]   add_a;
  logic [2:0]   add_b;
  logic         add_cin;
  logic [2:0]   add_sum;
  logic         add_cout;
`ifdef MULTIWORD_ADD_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

  multiword_add_sequencer #(.N_CHUNKS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
`ifdef MULTIWORD_ADD_OVF_EN
    .ovf      (ovf),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until done rises (bounded) and checks the edge count from acceptance.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 20);
    check({tag, "_latency"}, n, N);
  endtask

  task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] exp_r, input logic exp_c,
                         input logic exp_o);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(tag);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_cout"}, cout, exp_c);
`ifdef MULTIWORD_ADD_OVF_EN
    check({tag, "_ovf"}, ovf, exp_o);
`else
    if (exp_o) begin end
`endif
    $display("add %s: %03h + %03h + %0d -> result=%03h cout=%0d", tag, a, b, c, result, cout);
    step();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int seen_done;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_add_a", add_a, 0);
`ifdef MULTIWORD_ADD_OVF_EN
    check("rst_ovf", ovf, 0);
`endif

    run_add("basic", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);

    // Carry chain: 0xFFF + 0x001 must ripple a carry into every upper chunk.
    op_a  = 12'hFFF;
    op_b  = 12'h001;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("chain_c0_cin", add_cin, 0);
    check("chain_c0_a", add_a, 3'h7);
    check("chain_c0_b", add_b, 3'h1);
    step();
    check("chain_c1_cin", add_cin, 1);
    step();
    check("chain_c2_cin", add_cin, 1);
    step();
    check("chain_c3_cin", add_cin, 1);
    step();
    check("chain_done", done, 1);
    check("chain_result", result, 12'h000);
    check("chain_cout", cout, 1);
    $display("add chain: fff + 001 + 0 -> result=%03h cout=%0d", result, cout);
    step();

    run_add("allones", 12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0);

    // start held high through RUN and DONE: only the first request counts.
    op_a  = 12'h111;
    op_b  = 12'h222;
    cin   = 1'b0;
    start = 1'b1;
    step();
    op_a = 12'h7FF;
    op_b = 12'h7FF;
    wait_done("busyign");
    check("busyign_result", result, 12'h333);
    check("busyign_cout", cout, 0);
    $display("add busyign: 111 + 222 + 0 -> result=%03h cout=%0d", result, cout);
    step();
    check("busyign_idle_after_done", busy, 0);
    check("busyign_done_single", done, 0);
    step();
    start = 1'b0;
    check("busyign_restart_busy", busy, 1);
    wait_done("restart");
    check("restart_result", result, 12'hFFE);
    check("restart_cout", cout, 0);
`ifdef MULTIWORD_ADD_OVF_EN
    check("restart_ovf", ovf, 1);
`endif
    $display("add restart: 7ff + 7ff + 0 -> result=%03h cout=%0d", result, cout);
    step();

    // Reset during RUN aborts the operation.
    op_a  = 12'hABC;
    op_b  = 12'h123;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
    check("abort_add_a", add_a, 0);
    check("abort_add_b", add_b, 0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);
    $display("abort: rst mid-run -> busy=%0d result=%03h", busy, result);

    run_add("ovf_pos", 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    run_add("ovf_neg", 12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1'b1);
    run_add("ovf_mix", 12'h001, 12'hFFF, 1'b0, 12'h000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
